// File: rtl/mmu_pkg.sv
// Shared MMU types: arbiter state, the latched request record and an
// index-width helper used to size channel pointers.
package mmu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] vadd;
        logic [63:0] satp;
    } req_t;

    // Width of an index into n items; never zero so single-item cases still compile.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rrarb.sv
// Round-robin selector: picks the first set request bit strictly after
// the last granted index, wrapping around.
module rrarb
    import mmu_pkg::*;
#(
    parameter int width = 2,
    localparam int IW = idx_w(width)
) (
    input  logic [width-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [IW-1:0]    gnt,
    output logic             vld
);

    // Scan from last+1 around to last; the first hit wins.
    always_comb begin : scan
        int j;
        j   = 0;
        gnt = '0;
        vld = 1'b0;
        for (int k = 1; k <= width; k++) begin
            j = (int'(last) + k) % width;
            if (!vld && req[j]) begin
                vld = 1'b1;
                gnt = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tlb_arb.sv
// TLB miss arbiter: funnels per-channel translation requests to a single
// downstream PTW port, one outstanding request at a time, and routes the
// answer back to the channel that issued it.
// Optional watchdog enabled by defining TLB_ARB_TIMEOUT_EN.
module tlb_arb
    import mmu_pkg::*;
#(
    parameter int chn = 2,
    parameter int tmo = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [255:0]           flush,
    input  logic [chn-1:0][7:0]    s_rqst,
    input  logic [chn-1:0][63:0]   s_vadd,
    input  logic [chn-1:0][63:0]   s_satp,
    output logic [chn-1:0][7:0]    s_resp,
    output logic [chn-1:0][7:0]    s_perm,
    output logic [chn-1:0][63:0]   s_padd,
    output logic [7:0]             m_rqst,
    output logic [63:0]            m_vadd,
    output logic [63:0]            m_satp,
    input  logic [7:0]             m_resp,
    input  logic [7:0]             m_perm,
    input  logic [63:0]            m_padd
);

    localparam int CW = idx_w(chn);

    state_t          state;
    req_t            lat;
    logic [CW-1:0]   lat_ch;
    logic [CW-1:0]   last;
    logic [chn-1:0]  elig;
    logic [CW-1:0]   gnt;
    logic            gvld;
    logic            grant;
    logic            fl;
    logic            match;
    logic            tmo_fire;

    // A channel competes only with a live ID that is not being flushed.
    always_comb begin
        elig = '0;
        for (int i = 0; i < chn; i++) begin
            elig[i] = (s_rqst[i] != 8'h00) && !flush[s_rqst[i]];
        end
    end

    rrarb #(.width(chn)) u_rrarb (
        .req  (elig),
        .last (last),
        .gnt  (gnt),
        .vld  (gvld)
    );

    assign grant = (state == IDLE) && gvld;
    // Flush of the in-flight ID beats a coincident matching response.
    assign fl    = (state == BUSY) && flush[lat.id];
    assign match = (state == BUSY) && (m_resp == lat.id) && !fl;

`ifdef TLB_ARB_TIMEOUT_EN
    localparam int TW = idx_w(tmo + 1);
    logic [TW-1:0] cnt;

    // Watchdog: fires on the tmo-th BUSY cycle without an answer.
    assign tmo_fire = (state == BUSY) && !match && !fl && (cnt == TW'(tmo - 1));

    // Count BUSY cycles since the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (grant) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + TW'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^tmo;
    assign tmo_fire   = 1'b0;
`endif

    // Control FSM and round-robin pointer; pointer starts so channel 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= CW'(chn - 1);
        end else if (grant) begin
            state <= BUSY;
            last  <= gnt;
        end else if ((state == BUSY) && (fl || match || tmo_fire)) begin
            state <= IDLE;
        end
    end

    // Request latches; only meaningful while BUSY, so no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            lat.id   <= s_rqst[gnt];
            lat.vadd <= s_vadd[gnt];
            lat.satp <= s_satp[gnt];
            lat_ch   <= gnt;
        end
    end

    // Downstream request is withheld while the PTW is answering anything.
    always_comb begin
        m_rqst = ((state == BUSY) && (m_resp == 8'h00) && !tmo_fire) ? lat.id : 8'h00;
        m_vadd = lat.vadd;
        m_satp = lat.satp;
    end

    // Route the answer (or a watchdog page fault) to the granted channel only.
    always_comb begin
        s_resp = '0;
        s_perm = '0;
        s_padd = '0;
        if (match) begin
            s_resp[lat_ch] = m_resp;
            s_perm[lat_ch] = m_perm;
            s_padd[lat_ch] = m_padd;
        end else if (tmo_fire) begin
            s_resp[lat_ch] = lat.id;
        end
    end

endmodule

// File: tb/tb_tlb_arb.sv
// Self-checking bench for tlb_arb (chn=2): arbitration order, response
// routing, mismatched/late responses, flush, reset mid-request and, when
// TLB_ARB_TIMEOUT_EN is defined, the watchdog.
module tb_tlb_arb;

    logic                clk;
    logic                rst;
    logic [255:0]        flush;
    logic [1:0][7:0]     s_rqst;
    logic [1:0][63:0]    s_vadd;
    logic [1:0][63:0]    s_satp;
    logic [1:0][7:0]     s_resp;
    logic [1:0][7:0]     s_perm;
    logic [1:0][63:0]    s_padd;
    logic [7:0]          m_rqst;
    logic [63:0]         m_vadd;
    logic [63:0]         m_satp;
    logic [7:0]          m_resp;
    logic [7:0]          m_perm;
    logic [63:0]         m_padd;

    typedef struct {
        int          ch;
        logic [7:0]  id;
        logic [7:0]  perm;
        logic [63:0] padd;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_err;

    tlb_arb #(.chn(2), .tmo(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .s_rqst (s_rqst),
        .s_vadd (s_vadd),
        .s_satp (s_satp),
        .s_resp (s_resp),
        .s_perm (s_perm),
        .s_padd (s_padd),
        .m_rqst (m_rqst),
        .m_vadd (m_vadd),
        .m_satp (m_satp),
        .m_resp (m_resp),
        .m_perm (m_perm),
        .m_padd (m_padd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] id, input logic [7:0] perm,
                        input logic [63:0] padd);
        exp_t e;
        e.ch = ch; e.id = id; e.perm = perm; e.padd = padd;
        sb.push_back(e);
    endtask

    task automatic drive_resp(input logic [7:0] id, input logic [7:0] perm,
                              input logic [63:0] padd);
        m_resp = id; m_perm = perm; m_padd = padd;
    endtask

    // Compare any channel response against the scoreboard; idle channels must be all-zero.
    task automatic monitor();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            if (s_resp[c] != 8'h00) begin
                if (sb.size() == 0) begin
                    chk($sformatf("sb_unexpected_ch%0d", c), {56'h0, s_resp[c]}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ch",   c,         e.ch);
                    chk("sb_id",   s_resp[c], e.id);
                    chk("sb_perm", s_perm[c], e.perm);
                    chk("sb_padd", s_padd[c], e.padd);
                end
            end else begin
                chk($sformatf("idle_perm_ch%0d", c), s_perm[c], 64'h0);
                chk($sformatf("idle_padd_ch%0d", c), s_padd[c], 64'h0);
            end
        end
        chk("sb_missing", sb.size(), 0);
        sb.delete();
    endtask

    // Callers settle (#1 after the negedge) before checking; step then advances one cycle.
    task automatic step();
        monitor();
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        rst    = 1'b0;
        flush  = '0;
        s_rqst = '0;
        s_vadd = '0;
        s_satp = '0;
        drive_resp(8'h00, 8'h00, 64'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_rqst", m_rqst, 64'h0);
        chk("rst_s_resp", s_resp, 64'h0);
        @(negedge clk);

        // Both channels request together right after reset.
        rst       = 1'b1;
        s_rqst[0] = 8'h11; s_vadd[0] = 64'h8000_1000; s_satp[0] = 64'hA000_0000_0000_0001;
        s_rqst[1] = 8'h22; s_vadd[1] = 64'h9000_2000; s_satp[1] = 64'hB000_0000_0000_0002;
        #1; chk("idle_m_rqst", m_rqst, 64'h0); step();
        #1; chk("grant0_id", m_rqst, 64'h11);
            chk("grant0_vadd", m_vadd, 64'h8000_1000);
            chk("grant0_satp", m_satp, 64'hA000_0000_0000_0001); step();

        // Foreign response is ignored, but m_rqst drops while m_resp is non-zero.
        drive_resp(8'h33, 8'h55, 64'h1234);
        #1; chk("mismatch_m_rqst", m_rqst, 64'h0); step();
        drive_resp(8'h00, 8'h00, 64'h0);
        #1; chk("still_busy", m_rqst, 64'h11); step();

        // Matching response routed combinationally to ch0.
        drive_resp(8'h11, 8'h0f, 64'h8020_1000);
        push(0, 8'h11, 8'h0f, 64'h8020_1000);
        #1; chk("resp0_m_rqst", m_rqst, 64'h0);
            chk("resp0_ch1_zero", s_resp[1], 64'h0); step();

        // ch1 granted next.
        drive_resp(8'h00, 8'h00, 64'h0);
        s_rqst[0] = 8'h00;
        #1; chk("rr_idle", m_rqst, 64'h0); step();
        #1; chk("grant1_id", m_rqst, 64'h22);
            chk("grant1_vadd", m_vadd, 64'h9000_2000); step();
        drive_resp(8'h22, 8'h07, 64'h9030_2000);
        push(1, 8'h22, 8'h07, 64'h9030_2000);
        #1; step();

        // Flush coinciding with the matching response: flush wins.
        drive_resp(8'h00, 8'h00, 64'h0);
        s_rqst[1] = 8'h00;
        s_rqst[0] = 8'h11;
        #1; step();
        #1; chk("grant_fl_id", m_rqst, 64'h11); step();
        flush[8'h11] = 1'b1;
        s_rqst[0]    = 8'h00;
        drive_resp(8'h11, 8'h0f, 64'h8020_1000);
        #1; chk("flush_wins", s_resp, 64'h0); step();
        flush = '0;
        drive_resp(8'h00, 8'h00, 64'h0);
        #1; chk("flush_idle", m_rqst, 64'h0); step();
        drive_resp(8'h11, 8'h0f, 64'h8020_1000);
        #1; chk("late_resp_dropped", s_resp, 64'h0);
            chk("late_resp_m_rqst", m_rqst, 64'h0); step();

        // Identical IDs: last grant was ch0, so ch1 goes first.
        drive_resp(8'h00, 8'h00, 64'h0);
        s_rqst[0] = 8'h44; s_vadd[0] = 64'h4000_0000;
        s_rqst[1] = 8'h44; s_vadd[1] = 64'h4100_0000;
        #1; step();
        #1; chk("same_id_rqst", m_rqst, 64'h44);
            chk("same_id_vadd1", m_vadd, 64'h4100_0000); step();
        drive_resp(8'h44, 8'h03, 64'hC100_0000);
        push(1, 8'h44, 8'h03, 64'hC100_0000);
        #1; step();
        drive_resp(8'h00, 8'h00, 64'h0);
        s_rqst[1] = 8'h00;
        #1; step();
        drive_resp(8'h44, 8'h01, 64'hC000_0000);
        push(0, 8'h44, 8'h01, 64'hC000_0000);
        #1; chk("same_id_vadd0", m_vadd, 64'h4000_0000); step();

        // Reset mid-BUSY abandons the request.
        drive_resp(8'h00, 8'h00, 64'h0);
        s_rqst[0] = 8'h00;
        s_rqst[1] = 8'h55;
        #1; step();
        #1; chk("busy55", m_rqst, 64'h55); step();
        rst = 1'b0;
        #1; chk("rst_mid_m_rqst", m_rqst, 64'h0);
            chk("rst_mid_s_resp", s_resp, 64'h0); step();
        s_rqst[0] = 8'h77; s_vadd[0] = 64'h7000_0000;
        s_rqst[1] = 8'h66; s_vadd[1] = 64'h6000_0000;
        #1; step();
        rst = 1'b1;
        drive_resp(8'h55, 8'h0f, 64'h5555);
        #1; chk("post_rst_resp", s_resp, 64'h0); step();
        drive_resp(8'h00, 8'h00, 64'h0);
        #1; chk("post_rst_grant", m_rqst, 64'h77);
            chk("post_rst_vadd", m_vadd, 64'h7000_0000); step();
        drive_resp(8'h77, 8'h0b, 64'hF700_0000);
        push(0, 8'h77, 8'h0b, 64'hF700_0000);
        #1; step();
        drive_resp(8'h00, 8'h00, 64'h0);
        s_rqst = '0;
        #1; step();

`ifdef TLB_ARB_TIMEOUT_EN
        // Watchdog: no answer, page fault on the 8th BUSY cycle.
        s_rqst[1] = 8'h88;
        #1; step();
        s_rqst[1] = 8'h00;
        for (int k = 1; k < 8; k++) begin
            #1; chk($sformatf("tmo_wait%0d", k), m_rqst, 64'h88); step();
        end
        push(1, 8'h88, 8'h00, 64'h0);
        #1; chk("tmo_m_rqst", m_rqst, 64'h0); step();
        #1; chk("tmo_idle", m_rqst, 64'h0); step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tlb_arb.md
TLB_ARB -- requirements
Module: tlb_arb

Interface
REQ-001 Parameter chn, default 2: number of requesting TLB channels (1..8).
REQ-002 Parameter tmo, default 1023: watchdog limit in cycles; used only with TLB_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  256  flush bitmap indexed by request ID.
REQ-006 s_rqst  input  chn x 8  per-channel request ID; 0 = idle.
REQ-007 s_vadd  input  chn x 64  per-channel virtual address.
REQ-008 s_satp  input  chn x 64  per-channel SATP.
REQ-009 s_resp  output  chn x 8  per-channel response ID; 0 = none.
REQ-010 s_perm  output  chn x 8  per-channel permission; 0 = page fault.
REQ-011 s_padd  output  chn x 64  per-channel physical address.
REQ-012 m_rqst  output  8  request ID to PTW or higher-level TLB.
REQ-013 m_vadd  output  64  latched virtual address.
REQ-014 m_satp  output  64  latched SATP.
REQ-015 m_resp  input  8  response ID from PTW.
REQ-016 m_perm  input  8  permission from PTW.
REQ-017 m_padd  input  64  physical address from PTW.

Function
REQ-018 The block SHALL have two states: IDLE and BUSY, with at most one outstanding downstream request.
REQ-019 In IDLE, a channel is eligible when s_rqst != 0 and flush[s_rqst] == 0.
REQ-020 In IDLE, the block SHALL grant the first eligible channel round-robin, starting after the last granted channel. On grant it SHALL latch ID, vadd, satp and channel index, and move to BUSY on the next edge.
REQ-021 In BUSY, m_rqst SHALL equal the latched ID, except it SHALL be 0 in any cycle where m_resp != 0. m_vadd and m_satp SHALL come from the latches at all times.
REQ-022 In BUSY, when m_resp equals the latched ID, the block SHALL drive s_resp, s_perm and s_padd of the granted channel from m_resp, m_perm and m_padd combinationally in the same cycle, then return to IDLE.
REQ-023 m_resp values that do not match the latched ID, or that arrive while in IDLE, SHALL be discarded.
REQ-024 Non-granted channels SHALL see s_resp = 0 in every cycle.
REQ-025 flush[latched ID] in BUSY SHALL force IDLE on the next edge. If it coincides with a matching m_resp, flush wins: s_resp = 0 and the response is discarded.
REQ-026 After IDLE is re-entered, a later m_resp carrying an aborted ID SHALL be discarded.
REQ-027 Grant latency: request eligible in cycle t gives m_rqst != 0 in cycle t+1. Back-to-back: response in cycle r allows the next grant decision in cycle r+1.
REQ-028 Identical IDs on two channels SHALL be arbitrated normally. The response is routed only by the latched channel index.
REQ-029 When s_resp is 0, s_perm and s_padd SHALL be 0.

Reset
REQ-030 On reset: state IDLE, m_rqst 0, all s_resp 0, round-robin pointer set so channel 0 is granted first, watchdog counter 0. Data latches need no reset.
REQ-031 Reset asserted mid-BUSY SHALL abandon the request; no response is forwarded after release.

Configuration
REQ-032 With TLB_ARB_TIMEOUT_EN defined: a counter SHALL clear on grant and increment each BUSY cycle. When it reaches tmo with no matching m_resp, the block SHALL drive s_resp = latched ID, s_perm = 0 and s_padd = 0 on the granted channel for one cycle, m_rqst = 0 in that cycle, then return to IDLE.
REQ-033 Without TLB_ARB_TIMEOUT_EN: no counter SHALL exist, and BUSY SHALL persist until a matching response, flush or reset.

Structure
REQ-034 The state enum and the request record type (ID 8, vadd 64, satp 64) SHALL live in the shared package mmu_pkg.
REQ-035 Round-robin selection SHALL be a sub-module rrarb (parameter width; inputs req bitmap and last-grant pointer; outputs grant index and valid).

Verification
REQ-036 chn=2; ch0 rqst=0x11 and ch1 rqst=0x22 in the same cycle after reset -> m_rqst=0x11 next cycle. After m_resp=0x11, ch1 is granted and m_rqst=0x22.
REQ-037 Grant ch0 with vadd=0x8000_1000; m_resp=0x11, m_perm=0x0f, m_padd=0x8020_1000 -> same cycle s_resp[0]=0x11, s_perm[0]=0x0f, s_padd[0]=0x8020_1000, s_resp[1]=0, m_rqst=0.
REQ-038 BUSY with ID 0x11; flush[0x11]=1 -> IDLE next cycle. A later m_resp=0x11 -> all s_resp remain 0.
REQ-039 BUSY with ID 0x11; m_resp=0x33 -> ignored, still BUSY, m_rqst=0x11.
REQ-040 TLB_ARB_TIMEOUT_EN, tmo=8; grant with no m_resp -> at 8 BUSY cycles s_resp[g]=ID, s_perm[g]=0, then IDLE.
REQ-041 rst low mid-BUSY -> m_rqst=0 immediately, all s_resp=0. After release, ch0 is granted first.
